led_pattern_gen: RTL and testbench
==================================

// Module: led_pattern_gen
// PURPOSE
//  Multi-channel LED pattern generator; parametrised successor to the single fixed-period blinker.
//  Each of NUM_CH outputs runs an independent mode: OFF, ON, BLINK or BREATHE.
//  Per-channel mode, period and duty are set at run time through a valid/ready config port.
//  Sits between board-level LEDs and a control FSM or CSR bridge in the sys_clk domain.
// PARAMETERS
//  NUM_CH   4           number of LED channels (1..16)
//  CNT_W    32          width of the period/duty counters and config fields
//  PWM_W    8           breathe brightness resolution; the PWM carrier is 2^PWM_W clocks
//  DEF_PER  50_000_000  period loaded into every channel at reset
// PORTS
//  sys_clk    in   1                  system clock
//  rst_n      in   1                  reset: synchronous, active-low; clock sys_clk
//  cfg_valid  in   1                  config write request
//  cfg_ready  out  1                  block can accept a config write
//  cfg_ch     in   4                  target channel index
//  cfg_mode   in   2                  0 OFF, 1 ON, 2 BLINK, 3 BREATHE
//  cfg_period in   CNT_W              BLINK: cycles per period; BREATHE: cycles per brightness step
//  cfg_duty   in   CNT_W              BLINK: cycles high per period (ignored in other modes)
//  cfg_err    out  1                  1-cycle pulse: accepted write had cfg_ch >= NUM_CH
//  sync       in   1                  restart all channel phase counters together
//  led        out  NUM_CH             LED drive, registered, 1 = lit
// BEHAVIOUR
//  Reset
//  - led=0, cfg_ready=1, cfg_err=0.
//  - All channels: mode=BLINK, period=DEF_PER, duty=DEF_PER>>1; all counters 0.
//  - Reset mid-operation aborts everything; the block restarts from these values on the next edge.
//  Config handshake
//  - A write is accepted on an edge where cfg_valid & cfg_ready.
//  - cfg_ready is 0 for exactly the one cycle after an acceptance, then returns to 1.
//  - Accepted write loads mode/period/duty for cfg_ch and clears that channel's counters.
//  - The new behaviour is visible on led[cfg_ch] from the edge after acceptance.
//  - If cfg_ch >= NUM_CH, no state changes; cfg_err=1 on the following cycle.
//  Period arithmetic
//  - period=0 is treated as 1.
//  Per-channel phase counter ph
//  - Counts 0..period-1, then wraps to 0; unsigned, CNT_W bits.
//  - Wrap is compared on period-1, so there is no overflow at period=2^CNT_W-1.
//  Mode outputs (led is registered from the current ph and level)
//  - OFF: led=0. ON: led=1. ph is held at 0 in both.
//  - BLINK: led = (ph < duty). duty=0 gives always off; duty >= period gives always on.
//  - BREATHE: level is PWM_W bits, starts at 0 and steps by 1 on every ph wrap.
//  - BREATHE ramp: level rises to 2^PWM_W-1, then falls to 0, then repeats.
//  - BREATHE endpoints: the direction flips at each endpoint, and each endpoint is held for one step.
//  - BREATHE output: led = (pwm < level). pwm is a shared free-running PWM_W-bit counter.
//  Sync and simultaneous events
//  - sync=1 clears ph and level of every channel and sets the breathe direction to up; pwm is not cleared.
//  - A config write and sync on the same edge: the write applies to its channel; sync applies to the others.
//  - cfg_valid held high while cfg_ready=0: nothing is accepted. The request is taken on the next ready cycle.
// TESTING (NUM_CH=4, CNT_W=8, PWM_W=4, DEF_PER=10)
//  1. Release reset -> all led: 5 cycles high, then 5 low, repeating; all channels in phase.
//  2. Write ch1 BLINK, period=4, duty=1 -> led[1] = 1,0,0,0 repeating from the edge after acceptance;
//     cfg_ready low for 1 cycle.
//  3. Write ch2 duty=0, then duty=20 with period=8 -> led[2] constantly 0, then constantly 1.
//     Write ch3 OFF then ON -> led[3] constantly 0, then constantly 1.
//  4. Write ch0 BREATHE, period=1 -> level 0..15..0 over a 32-step cycle.
//     Per-16-cycle high count on led[0] equals level.
//  5. Write cfg_ch=7 -> cfg_err pulses once; led and config unchanged.
//     Back-to-back cfg_valid -> second write accepted 2 cycles after the first.
//  6. Drive sync mid-pattern, plus a ch1 write on the same edge -> ch0/2/3 restart at ph=0; ch1 takes new config.
//     Assert rst_n=0 mid-run -> reset values next edge.

Source files
------------

// File: rtl/led_pattern_gen_if.sv
// Configuration port of the LED pattern generator: one valid/ready write channel
// carrying the per-channel mode, period and duty, plus the bad-channel error pulse.
interface led_pattern_gen_if #(
    parameter int CNT_W = 32
) ();
    logic             cfg_valid;
    logic             cfg_ready;
    logic [3:0]       cfg_ch;
    logic [1:0]       cfg_mode;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_duty;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: each channel independently OFF, ON, BLINK
// (phase < duty) or BREATHE (triangle-ramped level compared against a shared PWM counter).
module led_pattern_gen #(
    parameter int          NUM_CH  = 4,
    parameter int          CNT_W   = 32,
    parameter int          PWM_W   = 8,
    parameter int unsigned DEF_PER = 50_000_000
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    led_pattern_gen_if.slave  cfg_if,
    input  logic              sync,
    output logic [NUM_CH-1:0] led
);
    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    localparam logic [CNT_W-1:0] DEF_PER_C  = CNT_W'(DEF_PER);
    localparam logic [CNT_W-1:0] DEF_DUTY_C = DEF_PER_C >> 1;
    localparam logic [4:0]       NUM_CH_C   = 5'(NUM_CH);
    localparam logic [PWM_W-1:0] LEVEL_MAX  = '1;

    mode_e            mode_q     [NUM_CH];
    mode_e            mode_d     [NUM_CH];
    logic [CNT_W-1:0] period_q   [NUM_CH];
    logic [CNT_W-1:0] period_d   [NUM_CH];
    logic [CNT_W-1:0] duty_q     [NUM_CH];
    logic [CNT_W-1:0] duty_d     [NUM_CH];
    logic [CNT_W-1:0] ph_q       [NUM_CH];
    logic [CNT_W-1:0] ph_d       [NUM_CH];
    logic [PWM_W-1:0] level_q    [NUM_CH];
    logic [PWM_W-1:0] level_d    [NUM_CH];
    logic             dir_down_q [NUM_CH];
    logic             dir_down_d [NUM_CH];

    logic [PWM_W-1:0]  pwm_q, pwm_d;
    logic [NUM_CH-1:0] led_q, led_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              cfg_err_q, cfg_err_d;

    logic accept;
    logic ch_ok;
    logic wr_en;

    // A zero period behaves as a period of one, so its last phase is also 0.
    function automatic logic [CNT_W-1:0] last_phase(input logic [CNT_W-1:0] period);
        return (period == '0) ? '0 : period - CNT_W'(1);
    endfunction

    assign accept = cfg_if.cfg_valid & cfg_ready_q;
    assign ch_ok  = ({1'b0, cfg_if.cfg_ch} < NUM_CH_C);
    assign wr_en  = accept & ch_ok;

    always_comb begin
        cfg_ready_d = ~accept;
        cfg_err_d   = accept & ~ch_ok;
        pwm_d       = pwm_q + PWM_W'(1);
        led_d       = '0;

        for (int i = 0; i < NUM_CH; i++) begin
            mode_d[i]     = mode_q[i];
            period_d[i]   = period_q[i];
            duty_d[i]     = duty_q[i];
            ph_d[i]       = ph_q[i];
            level_d[i]    = level_q[i];
            dir_down_d[i] = dir_down_q[i];

            case (mode_q[i])
                MODE_OFF:     led_d[i] = 1'b0;
                MODE_ON:      led_d[i] = 1'b1;
                MODE_BLINK:   led_d[i] = (ph_q[i] < duty_q[i]);
                MODE_BREATHE: led_d[i] = (pwm_q < level_q[i]);
            endcase

            if (mode_q[i] == MODE_BLINK || mode_q[i] == MODE_BREATHE) begin
                if (ph_q[i] >= last_phase(period_q[i])) begin
                    ph_d[i] = '0;
                    // Breathe level moves one step per phase wrap; endpoints hold one step while turning.
                    if (mode_q[i] == MODE_BREATHE) begin
                        if (!dir_down_q[i]) begin
                            if (level_q[i] == LEVEL_MAX) dir_down_d[i] = 1'b1;
                            else                         level_d[i]    = level_q[i] + PWM_W'(1);
                        end else begin
                            if (level_q[i] == '0) dir_down_d[i] = 1'b0;
                            else                  level_d[i]    = level_q[i] - PWM_W'(1);
                        end
                    end
                end else begin
                    ph_d[i] = ph_q[i] + CNT_W'(1);
                end
            end else begin
                ph_d[i] = '0;
            end

            // A write to this channel takes priority over a simultaneous sync.
            if (wr_en && cfg_if.cfg_ch == 4'(i)) begin
                mode_d[i]     = mode_e'(cfg_if.cfg_mode);
                period_d[i]   = cfg_if.cfg_period;
                duty_d[i]     = cfg_if.cfg_duty;
                ph_d[i]       = '0;
                level_d[i]    = '0;
                dir_down_d[i] = 1'b0;
            end else if (sync) begin
                ph_d[i]       = '0;
                level_d[i]    = '0;
                dir_down_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= 1'b0;
            pwm_q       <= '0;
            led_q       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i]     <= MODE_BLINK;
                period_q[i]   <= DEF_PER_C;
                duty_q[i]     <= DEF_DUTY_C;
                ph_q[i]       <= '0;
                level_q[i]    <= '0;
                dir_down_q[i] <= 1'b0;
            end
        end else begin
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
            pwm_q       <= pwm_d;
            led_q       <= led_d;
            mode_q      <= mode_d;
            period_q    <= period_d;
            duty_q      <= duty_d;
            ph_q        <= ph_d;
            level_q     <= level_d;
            dir_down_q  <= dir_down_d;
        end
    end

    assign cfg_if.cfg_ready = cfg_ready_q;
    assign cfg_if.cfg_err   = cfg_err_q;
    assign led              = led_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: age-based reference model checked every cycle,
// plus directed writes with hand-computed literal expectations.
module tb_led_pattern_gen;
    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 8;
    localparam int PWM_W   = 4;
    localparam int DEF_PER = 10;
    localparam int LV      = 1 << PWM_W;

    logic              sys_clk = 1'b0;
    logic              rst_n   = 1'b0;
    logic              sync    = 1'b0;
    logic [NUM_CH-1:0] led;

    led_pattern_gen_if #(.CNT_W(CNT_W)) cfg_if ();

    led_pattern_gen #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .PWM_W  (PWM_W),
        .DEF_PER(DEF_PER)
    ) dut (
        .sys_clk(sys_clk),
        .rst_n  (rst_n),
        .cfg_if (cfg_if),
        .sync   (sync),
        .led    (led)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: each channel tracks only its age since the last restart.
    int m_mode [NUM_CH];
    int m_per  [NUM_CH];
    int m_duty [NUM_CH];
    int m_age  [NUM_CH];
    int m_pwm = 0;
    logic [NUM_CH-1:0] exp_led = '0;
    logic exp_ready = 1'b1;
    logic exp_err   = 1'b0;

    function automatic logic model_led(input int i);
        int p, k, lvl;
        p = (m_per[i] == 0) ? 1 : m_per[i];
        case (m_mode[i])
            0: return 1'b0;
            1: return 1'b1;
            2: return (m_age[i] % p) < m_duty[i];
            default: begin
                k   = (m_age[i] / p) % (2 * LV);
                lvl = (k < LV) ? k : (2 * LV - 1 - k);
                return m_pwm < lvl;
            end
        endcase
    endfunction

    always @(posedge sys_clk) begin
        bit acc;
        int ch;
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_mode[i] = 2;
                m_per[i]  = DEF_PER;
                m_duty[i] = DEF_PER / 2;
                m_age[i]  = 0;
            end
            m_pwm     = 0;
            exp_led   = '0;
            exp_ready = 1'b1;
            exp_err   = 1'b0;
        end else begin
            acc = cfg_if.cfg_valid && exp_ready;
            ch  = int'(cfg_if.cfg_ch);
            for (int i = 0; i < NUM_CH; i++) exp_led[i] = model_led(i);
            exp_err   = acc && (ch >= NUM_CH);
            exp_ready = !acc;
            m_pwm     = (m_pwm + 1) % LV;
            for (int i = 0; i < NUM_CH; i++) begin
                m_age[i]++;
                if (sync) m_age[i] = 0;
            end
            if (acc && ch < NUM_CH) begin
                m_mode[ch] = int'(cfg_if.cfg_mode);
                m_per[ch]  = int'(cfg_if.cfg_period);
                m_duty[ch] = int'(cfg_if.cfg_duty);
                m_age[ch]  = 0;
            end
        end
    end

    always @(negedge sys_clk) begin
        if (cyc > 0) begin
            chk("model_led",   32'(led),              32'(exp_led));
            chk("model_ready", 32'(cfg_if.cfg_ready), 32'(exp_ready));
            chk("model_err",   32'(cfg_if.cfg_err),   32'(exp_err));
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic cfg_write(input int ch, input int mode, input int per, input int duty);
        int n;
        n = 0;
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_ch     = 4'(ch);
        cfg_if.cfg_mode   = 2'(mode);
        cfg_if.cfg_period = CNT_W'(per);
        cfg_if.cfg_duty   = CNT_W'(duty);
        while (!cfg_if.cfg_ready && n < 8) begin
            @(negedge sys_clk);
            n++;
        end
        if (!cfg_if.cfg_ready) chk("cfg_accept_timeout", 32'(cfg_if.cfg_ready), 32'd1);
        @(posedge sys_clk);
        @(negedge sys_clk);
        last_acc = cyc;
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic expect_bit(input string name, input int ch, input logic val, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge sys_clk);
            chk(name, 32'(led[ch]), 32'(val));
        end
    endtask

    initial begin
        int a, cnt;
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_ch     = '0;
        cfg_if.cfg_mode   = '0;
        cfg_if.cfg_period = '0;
        cfg_if.cfg_duty   = '0;

        repeat (3) @(negedge sys_clk);
        chk("rst_led",   32'(led),              32'h0);
        chk("rst_ready", 32'(cfg_if.cfg_ready), 32'h1);
        chk("rst_err",   32'(cfg_if.cfg_err),   32'h0);
        rst_n = 1'b1;

        // Default blink: 5 high, 5 low, all channels in phase.
        for (int k = 0; k < 20; k++) begin
            @(negedge sys_clk);
            chk("t1_default_blink", 32'(led), ((k % 10) < 5) ? 32'hF : 32'h0);
        end

        cfg_write(1, 2, 4, 1);
        chk("t2_ready_low", 32'(cfg_if.cfg_ready), 32'h0);
        for (int k = 0; k < 8; k++) begin
            @(negedge sys_clk);
            if (k == 0) chk("t2_ready_back", 32'(cfg_if.cfg_ready), 32'h1);
            chk("t2_ch1_blink", 32'(led[1]), ((k % 4) == 0) ? 32'h1 : 32'h0);
        end

        cfg_write(2, 2, 8, 0);
        expect_bit("t3_duty_zero", 2, 1'b0, 10);
        cfg_write(2, 2, 8, 20);
        expect_bit("t3_duty_over", 2, 1'b1, 10);
        cfg_write(2, 2, 0, 1);
        expect_bit("t3_period_zero", 2, 1'b1, 6);
        cfg_write(3, 0, 5, 5);
        expect_bit("t3_off", 3, 1'b0, 8);
        cfg_write(3, 1, 5, 0);
        expect_bit("t3_on", 3, 1'b1, 8);

        cfg_write(0, 3, 1, 0);
        repeat (80) @(negedge sys_clk);
        // Step of 16 cycles: each window sees every pwm value once, so high count equals level.
        cfg_write(0, 3, 16, 0);
        for (int w = 0; w < 4; w++) begin
            cnt = 0;
            for (int k = 0; k < 16; k++) begin
                @(negedge sys_clk);
                cnt += int'(led[0]);
            end
            chk("t4_breathe_window", 32'(cnt), 32'(w));
        end

        cfg_write(7, 1, 3, 3);
        chk("t5_err_pulse", 32'(cfg_if.cfg_err), 32'h1);
        @(negedge sys_clk);
        chk("t5_err_clear", 32'(cfg_if.cfg_err), 32'h0);
        cfg_write(1, 2, 6, 3);
        a = last_acc;
        cfg_write(2, 2, 6, 2);
        chk("t5_back_to_back_gap", 32'(last_acc - a), 32'd2);

        cfg_write(0, 2, 10, 5);
        repeat (3) @(negedge sys_clk);
        cfg_write(2, 2, 10, 5);
        repeat (2) @(negedge sys_clk);
        cfg_write(3, 2, 10, 5);
        repeat (4) @(negedge sys_clk);
        chk("t6_ready_before", 32'(cfg_if.cfg_ready), 32'h1);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_ch     = 4'd1;
        cfg_if.cfg_mode   = 2'd1;
        cfg_if.cfg_period = CNT_W'(3);
        cfg_if.cfg_duty   = CNT_W'(0);
        sync = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        cfg_if.cfg_valid = 1'b0;
        sync = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge sys_clk);
            chk("t6_sync_ch0", 32'(led[0]), (k < 5) ? 32'h1 : 32'h0);
            chk("t6_sync_ch2", 32'(led[2]), (k < 5) ? 32'h1 : 32'h0);
            chk("t6_sync_ch3", 32'(led[3]), (k < 5) ? 32'h1 : 32'h0);
            chk("t6_ch1_on",   32'(led[1]), 32'h1);
        end

        repeat (3) @(negedge sys_clk);
        rst_n = 1'b0;
        @(negedge sys_clk);
        chk("t6_midrun_rst_led",   32'(led),              32'h0);
        chk("t6_midrun_rst_ready", 32'(cfg_if.cfg_ready), 32'h1);
        chk("t6_midrun_rst_err",   32'(cfg_if.cfg_err),   32'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge sys_clk);
            chk("t6_after_rst_blink", 32'(led), ((k % 10) < 5) ? 32'hF : 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
